mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control unit for the MIPS core. It sequences a shared-memory multicycle datapath through fetch, decode, execute, memory and writeback states for every instruction. It drives all datapath mux selects and write enables, and handles wait states on the unified instruction/data memory through a request/ready handshake. It replaces the single-cycle combinational decode when the core is built in multicycle form.

## Interface
Parameters:
- none; encodings are fixed.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: **asynchronous, active-low** reset. 0 forces state FETCH immediately.
- `op` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access active.
- `iord` out 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `memwrite` out 1: memory write.
- `irwrite` out 1: instruction register load.
- `pcen` out 1: PC load, equal to pcwrite | (branch & zero).
- `regdst` out 1: write register select. 0 selects rt; 1 selects rd.
- `memtoreg` out 1: writeback select. 0 selects ALUOut; 1 selects Data.
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A select. 0 selects PC; 1 selects register A.
- `alusrcb` out 2: ALU B select. 00 selects B; 01 selects 4; 10 selects SignImm; 11 selects SignImm<<2.
- `pcsrc` out 2: next-PC select. 00 selects ALUResult; 01 selects ALUOut; 10 selects the jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported op, or in EXECUTE for an unsupported funct.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `state` out 4: current state, for debug.

## Operation
- Registered 4-bit state; all outputs are Moore functions of state, except the items below:
  - pcen uses `zero`.
  - Handshake gating uses `mem_ready`.
  - alucontrol uses `funct`.
- Any output not listed for a state is 0. aluop is internal.
- States, with their asserted outputs and transitions:
  - **FETCH (0):** mem_req, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
    - irwrite and pcwrite are asserted only when mem_ready=1.
    - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
  - **DECODE (1):** alusrca=0, alusrcb=11, aluop=00. Next state by op:
    - 100011 or 101011 → MEMADR.
    - 000000 → EXECUTE.
    - 000100 → BRANCH.
    - 001000 → ADDIEX.
    - 000010 → JUMP.
    - Any other op → FETCH, with illegal=1.
  - **MEMADR (2):** alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
  - **MEMRD (3):** mem_req, iord=1. Stays while mem_ready=0; otherwise goes to MEMWB.
  - **MEMWB (4):** regdst=0, memtoreg=1, regwrite, instr_done. Goes to FETCH.
  - **MEMWR (5):** mem_req, iord=1, memwrite. memwrite is held every cycle until mem_ready=1; then instr_done and go to FETCH.
  - **EXECUTE (6):** alusrca=1, alusrcb=00, aluop=10.
    - Goes to ALUWB.
    - For an unsupported funct: alucontrol=010, illegal=1, and the next state is FETCH, so no writeback occurs.
  - **ALUWB (7):** regdst=1, memtoreg=0, regwrite, instr_done. Goes to FETCH.
  - **BRANCH (8):** alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch, instr_done. Goes to FETCH.
  - **ADDIEX (9):** alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
  - **ADDIWB (10):** regdst=0, memtoreg=0, regwrite, instr_done. Goes to FETCH.
  - **JUMP (11):** pcsrc=10, pcwrite, instr_done. Goes to FETCH.
  - **Unused encodings 12–15:** all outputs 0; next state is FETCH.
- ALU decode:
  - aluop 00 gives 010; aluop 01 gives 110.
  - aluop 10 decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, anything else→010.
  - No X values are driven on any output.

## Timing
- State is updated on the rising edge of `clk`. Outputs are combinational from state and inputs, valid in the same cycle.
- While reset=0 the state is FETCH, and outputs take the FETCH values with mem_ready masked to 0:
  - mem_req=1, alusrcb=01, alucontrol=010.
  - All other outputs are 0, including pcen, irwrite, regwrite, memwrite, illegal and instr_done.
- Reset deassertion: the first rising edge after reset goes high evaluates FETCH normally.
- Reset mid-instruction abandons the instruction immediately: no further regwrite, memwrite or pcen.
- With zero wait states, cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_ready=0 during FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state where mem_req=0.
- mem_ready=1 held permanently gives zero-wait behaviour.
- Exactly one instr_done pulse per completed instruction. Illegal instructions pulse `illegal` and never pulse instr_done.

## Test plan
- **lw, no waits.** op=100011, mem_ready=1.
  - Required sequence: FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH (5 cycles).
  - regwrite=1, memtoreg=1, regdst=0 only in MEMWB.
- **sw, waits.** op=101011, with mem_ready=0 for 2 cycles in both FETCH and MEMWR.
  - FETCH lasts 3 cycles, with irwrite=1 only in its last cycle.
  - memwrite=1 for 3 consecutive cycles; total 8 cycles; one instr_done.
- **beq.** op=000100.
  - zero=1: pcen=1 and pcsrc=01 in BRANCH.
  - zero=0: pcen=0; 3 cycles in both cases.
- **R-type decode.** Apply each funct in 100000/100010/100100/100101/101010:
  - Required alucontrol in EXECUTE: 010/110/000/001/111.
  - funct=000000 gives alucontrol=010, illegal=1, and no ALUWB.
- **Illegal op and jump.**
  - op=111111: illegal pulses in DECODE, then FETCH, with regwrite, memwrite and pcen all 0.
  - op=000010: JUMP with pcsrc=10 and pcen=1.
- **Async reset.** Drop reset mid-MEMWR, between clock edges.
  - memwrite falls within the same cycle and state=0.
  - After reset is released, a fresh fetch begins.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle controller and the datapath.
// master: controller side (decode inputs in, control strobes out); slave: datapath/bench side.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic       instr_done;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal,
               instr_done, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
               regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal,
               instr_done, state
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Ports: clk, reset (async, active-low), bus (master modport of mips_mc_controller_if).
module mips_mc_controller (
    input  logic                  clk,
    input  logic                  reset,
    mips_mc_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q, state_d;

    logic       rdy;
    logic       funct_ok;
    logic       pcwrite, branch;
    logic [1:0] aluop;
    logic       mem_req, iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       illegal, instr_done;
    logic [2:0] alucontrol;

    // While reset is held the FSM sits in FETCH; masking ready keeps
    // irwrite/pcen low so nothing is committed during reset.
    assign rdy = bus.mem_ready & reset;

    always_comb begin
        funct_ok = 1'b0;
        case (bus.funct)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: funct_ok = 1'b1;
            default:              funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (rdy) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                unique case (1'b1)
                    (bus.op == OP_LW),
                    (bus.op == OP_SW):   state_d = S_MEMADR;
                    (bus.op == OP_RTYP): state_d = S_EXECUTE;
                    (bus.op == OP_BEQ):  state_d = S_BRANCH;
                    (bus.op == OP_ADDI): state_d = S_ADDIEX;
                    (bus.op == OP_J):    state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (rdy) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                if (funct_ok) begin
                    state_d = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.iord       = iord;
    assign bus.memwrite   = memwrite;
    assign bus.irwrite    = irwrite;
    assign bus.pcen       = pcwrite | (branch & bus.zero);
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.illegal    = illegal;
    assign bus.instr_done = instr_done;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: per-instruction cycle-sequence model,
// randomized instructions/wait states, directed cases and async reset abort.
module tb_mips_mc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
        logic       illegal;
        logic       done;
    } exp_t;

    typedef struct {
        exp_t e;
        logic rdy;
        logic z;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   ncyc  = 0;
    cyc_t q[$];

    always #5 clk = ~clk;

    mips_mc_controller_if bus();

    mips_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st       = bus.state;
        a.mem_req  = bus.mem_req;
        a.iord     = bus.iord;
        a.memwrite = bus.memwrite;
        a.irwrite  = bus.irwrite;
        a.pcen     = bus.pcen;
        a.regdst   = bus.regdst;
        a.memtoreg = bus.memtoreg;
        a.regwrite = bus.regwrite;
        a.alusrca  = bus.alusrca;
        a.alusrcb  = bus.alusrcb;
        a.pcsrc    = bus.pcsrc;
        a.alu      = bus.alucontrol;
        a.illegal  = bus.illegal;
        a.done     = bus.instr_done;
        return a;
    endfunction

    function automatic logic [2:0] falu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic logic pickz(input int zm);
        if (zm == 2) return 1'($urandom % 2);
        return (zm == 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input exp_t act, input exp_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (st %0d vs %0d)",
                     name, act, exp, act.st, exp.st);
        end
    endtask

    task automatic push(input exp_t e, input logic rdy, input logic z);
        cyc_t c;
        c.e   = e;
        c.rdy = rdy;
        c.z   = z;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle outputs of one instruction, from the
    // instruction class, wait counts and zero flag choice.
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int mw, input int zm);
        exp_t e;
        logic z;
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            e         = blank(4'd0);
            e.mem_req = 1'b1;
            e.alusrcb = 2'b01;
            if (i == fw) begin
                e.irwrite = 1'b1;
                e.pcen    = 1'b1;
            end
            push(e, i == fw, pickz(zm));
        end
        e         = blank(4'd1);
        e.alusrcb = 2'b11;
        case (op)
            6'b100011, 6'b101011, 6'b000000,
            6'b000100, 6'b001000, 6'b000010: ;
            default: e.illegal = 1'b1;
        endcase
        push(e, 1'($urandom % 2), pickz(zm));
        if (e.illegal) return;
        case (op)
            6'b100011, 6'b101011: begin
                e         = blank(4'd2);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                push(e, 1'($urandom % 2), pickz(zm));
                for (int i = 0; i <= mw; i++) begin
                    e          = blank(op == 6'b100011 ? 4'd3 : 4'd5);
                    e.mem_req  = 1'b1;
                    e.iord     = 1'b1;
                    e.memwrite = (op == 6'b101011);
                    e.done     = (op == 6'b101011) && (i == mw);
                    push(e, i == mw, pickz(zm));
                end
                if (op == 6'b100011) begin
                    e          = blank(4'd4);
                    e.memtoreg = 1'b1;
                    e.regwrite = 1'b1;
                    e.done     = 1'b1;
                    push(e, 1'($urandom % 2), pickz(zm));
                end
            end
            6'b000000: begin
                e         = blank(4'd6);
                e.alusrca = 1'b1;
                e.alu     = falu(fn);
                e.illegal = !fn_ok(fn);
                push(e, 1'($urandom % 2), pickz(zm));
                if (fn_ok(fn)) begin
                    e          = blank(4'd7);
                    e.regdst   = 1'b1;
                    e.regwrite = 1'b1;
                    e.done     = 1'b1;
                    push(e, 1'($urandom % 2), pickz(zm));
                end
            end
            6'b000100: begin
                z         = pickz(zm);
                e         = blank(4'd8);
                e.alusrca = 1'b1;
                e.alu     = 3'b110;
                e.pcsrc   = 2'b01;
                e.pcen    = z;
                e.done    = 1'b1;
                push(e, 1'($urandom % 2), z);
            end
            6'b001000: begin
                e         = blank(4'd9);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                push(e, 1'($urandom % 2), pickz(zm));
                e          = blank(4'd10);
                e.regwrite = 1'b1;
                e.done     = 1'b1;
                push(e, 1'($urandom % 2), pickz(zm));
            end
            default: begin
                e       = blank(4'd11);
                e.pcsrc = 2'b10;
                e.pcen  = 1'b1;
                e.done  = 1'b1;
                push(e, 1'($urandom % 2), pickz(zm));
            end
        endcase
    endtask

    function automatic exp_t reset_vec();
        exp_t e;
        e         = blank(4'd0);
        e.mem_req = 1'b1;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    // Drop reset between edges with mem_ready high; outputs must fall to
    // the masked FETCH values at once and stay there across an edge.
    task automatic do_abort();
        #1;
        bus.mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        chkv("async_reset_now", sample(), reset_vec());
        @(posedge clk);
        #1;
        chkv("async_reset_held", sample(), reset_vec());
        reset = 1'b1;
    endtask

    // Called just after a rising edge; each entry is one clock cycle.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input int fw, input int mw, input int zm,
                       input int abort_at);
        build(op, fn, fw, mw, zm);
        bus.op    = op;
        bus.funct = fn;
        for (int i = 0; i < q.size(); i++) begin
            bus.mem_ready = q[i].rdy;
            bus.zero      = q[i].z;
            @(negedge clk);
            chkv($sformatf("cyc%0d op%h st%0d", ncyc, op, q[i].e.st),
                 sample(), q[i].e);
            ncyc++;
            if (i == abort_at) begin
                do_abort();
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        int idx;
        logic [5:0] op, fn;
        logic [5:0] rf[5];
        rf[0] = 6'b100000; rf[1] = 6'b100010; rf[2] = 6'b100100;
        rf[3] = 6'b100101; rf[4] = 6'b101010;

        bus.op        = 6'b100011;
        bus.funct     = 6'b0;
        bus.zero      = 1'b1;
        bus.mem_ready = 1'b1;
        #12;
        chkv("reset_state", sample(), reset_vec());
        @(posedge clk);
        #1;
        chkv("reset_over_edge", sample(), reset_vec());
        reset = 1'b1;

        // Hand-computed pins on the model itself.
        build(6'b100011, 6'b0, 0, 0, 1);
        chk("lw_len", q.size(), 5);
        chk("lw_regwrite_st", q[4].e.st, 4);
        build(6'b101011, 6'b0, 2, 2, 1);
        chk("sw_len", q.size(), 8);
        cnt = 0; idx = -1;
        foreach (q[i]) begin
            cnt += q[i].e.memwrite;
            if (q[i].e.irwrite) idx = i;
        end
        chk("sw_memwrite_cycles", cnt, 3);
        chk("sw_irwrite_idx", idx, 2);
        build(6'b000100, 6'b0, 0, 0, 1);
        chk("beq_len", q.size(), 3);
        chk("beq_pcen_z1", q[2].e.pcen, 1);
        build(6'b000100, 6'b0, 0, 0, 0);
        chk("beq_pcen_z0", q[2].e.pcen, 0);
        build(6'b111111, 6'b0, 0, 0, 1);
        chk("illegal_len", q.size(), 2);
        build(6'b000000, 6'b000000, 0, 0, 1);
        chk("bad_funct_len", q.size(), 3);
        chk("alu_sub", falu(6'b100010), 3'b110);
        chk("alu_slt", falu(6'b101010), 3'b111);

        // Directed sequences against the DUT.
        run(6'b100011, 6'b0, 0, 0, 1, -1);
        run(6'b101011, 6'b0, 2, 2, 1, -1);
        run(6'b000100, 6'b0, 0, 0, 1, -1);
        run(6'b000100, 6'b0, 0, 0, 0, -1);
        for (int i = 0; i < 5; i++) run(6'b000000, rf[i], 0, 0, 2, -1);
        run(6'b000000, 6'b000000, 0, 0, 2, -1);
        run(6'b111111, 6'b0, 0, 0, 2, -1);
        run(6'b000010, 6'b0, 0, 0, 2, -1);
        run(6'b001000, 6'b0, 1, 0, 2, -1);
        run(6'b101011, 6'b0, 0, 3, 1, 4);
        run(6'b100011, 6'b0, 1, 1, 2, -1);

        // Randomized instructions and wait states.
        for (int n = 0; n < 300; n++) begin
            case ($urandom % 8)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b111111;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom % 4 != 0) ? rf[$urandom % 5] : 6'($urandom);
            run(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                (n % 37 == 36) ? $urandom_range(0, 1) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
